// File: rtl/fetch_stage.sv
// Purpose: RV32I instruction-fetch stage; owns the PC, captures imem data into the IF/ID register.
// Latency: the instruction at o_imem_pc appears on o_id_* one edge later; a redirect target is valid in IF/ID two edges after the redirect.
// Backpressure: i_stall freezes the PC and IF/ID; i_redirect overrides a stall and loads a NOP bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic [31:0]      i_redirect_target,
    input  logic [31:0]      i_imem_instr,
    output logic [31:0]      o_imem_pc,
    output logic [31:0]      o_id_pc,
    output logic [31:0]      o_id_pc4,
    output logic [31:0]      o_id_instr,
    output logic             o_id_valid,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_fetch_cnt,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    ifid_t            ifid;
    logic             misalign;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // Sequential PC increment; 32-bit wrap past FFFF_FFFC is intentional.
    assign pc_plus4 = pc + 32'd4;

    // PC, IF/ID and counters: reset > redirect > stall > normal fetch
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc         <= RESET_VEC;
            ifid       <= IFID_BUBBLE;
            misalign   <= 1'b0;
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (i_redirect) begin
            // The instruction currently being fetched is squashed, so it is not counted.
            pc         <= {i_redirect_target[31:2], 2'b00};
            ifid       <= IFID_BUBBLE;
            bubble_cnt <= bubble_cnt + CNT_ONE;
            if (i_redirect_target[1:0] != 2'b00) begin
                misalign <= 1'b1;
            end
        end else if (!i_stall) begin
            pc         <= pc_plus4;
            ifid.pc    <= pc;
            ifid.pc4   <= pc_plus4;
            ifid.instr <= i_imem_instr;
            ifid.valid <= 1'b1;
            fetch_cnt  <= fetch_cnt + CNT_ONE;
        end
    end

    assign o_imem_pc    = pc;
    assign o_id_pc      = ifid.pc;
    assign o_id_pc4     = ifid.pc4;
    assign o_id_instr   = ifid.instr;
    assign o_id_valid   = ifid.valid;
    assign o_misalign   = misalign;
    assign o_fetch_cnt  = fetch_cnt;
    assign o_bubble_cnt = bubble_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: self-checking bench for fetch_stage against an in-bench behavioural model.
// Latency: model advances once per rising edge; outputs compared on every falling edge.
// Backpressure: stall/redirect/reset driven by directed steps, then randomized.
module tb_fetch_stage;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_target = 32'h0;
    logic [31:0] i_imem_instr;
    logic [31:0] o_imem_pc, o_id_pc, o_id_pc4, o_id_instr;
    logic        o_id_valid, o_misalign;
    logic [31:0] o_fetch_cnt, o_bubble_cnt;

    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_VEC(RESET_VEC), .NOP_INSTR(NOP_INSTR), .CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_redirect(i_redirect),
        .i_redirect_target(i_redirect_target), .i_imem_instr(i_imem_instr),
        .o_imem_pc(o_imem_pc), .o_id_pc(o_id_pc), .o_id_pc4(o_id_pc4),
        .o_id_instr(o_id_instr), .o_id_valid(o_id_valid), .o_misalign(o_misalign),
        .o_fetch_cnt(o_fetch_cnt), .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Combinational instruction memory indexed by pc[13:2]
    assign i_imem_instr = mem[o_imem_pc[13:2]];

    // ---------------- behavioural model ----------------
    // What the pipeline should hold: the fetch address, the last accepted
    // instruction (or a bubble) and running event totals.
    logic [31:0] m_pc;
    logic [31:0] m_id_pc, m_id_pc4, m_id_instr;
    logic        m_id_valid;
    bit          m_misalign;
    int unsigned m_fetches, m_bubbles;
    bit          m_live = 1'b0;

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_live     = 1'b1;
            m_pc       = RESET_VEC;
            m_id_pc    = 0;
            m_id_pc4   = 0;
            m_id_instr = NOP_INSTR;
            m_id_valid = 1'b0;
            m_misalign = 1'b0;
            m_fetches  = 0;
            m_bubbles  = 0;
        end else if (m_live && i_redirect) begin
            m_pc       = i_redirect_target & ~32'h3;
            m_id_pc    = 0;
            m_id_pc4   = 0;
            m_id_instr = NOP_INSTR;
            m_id_valid = 1'b0;
            m_bubbles  = m_bubbles + 1;
            if (i_redirect_target % 4 != 0) m_misalign = 1'b1;
        end else if (m_live && !i_stall) begin
            m_id_pc    = m_pc;
            m_id_pc4   = m_pc + 4;
            m_id_instr = mem[(m_pc / 4) % 4096];
            m_id_valid = 1'b1;
            m_pc       = m_pc + 4;
            m_fetches  = m_fetches + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge
    always @(negedge i_clk) begin
        if (m_live) begin
            chk("imem_pc",    o_imem_pc,    m_pc);
            chk("id_pc",      o_id_pc,      m_id_pc);
            chk("id_pc4",     o_id_pc4,     m_id_pc4);
            chk("id_instr",   o_id_instr,   m_id_instr);
            chk("id_valid",   {31'h0, o_id_valid}, {31'h0, m_id_valid});
            chk("misalign",   {31'h0, o_misalign}, {31'h0, m_misalign});
            chk("fetch_cnt",  o_fetch_cnt,  m_fetches);
            chk("bubble_cnt", o_bubble_cnt, m_bubbles);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        for (int n = 0; n < 4096; n++) mem[n] = 32'h1000_0000 + n;

        // Reset, then two captures
        i_rst = 1'b1; tick();
        chk("lit_rst_pc",    o_imem_pc, 32'h0);
        chk("lit_rst_instr", o_id_instr, 32'h0000_0013);
        chk("lit_rst_valid", {31'h0, o_id_valid}, 32'h0);
        i_rst = 1'b0; tick();
        chk("lit_cap0_pc",    o_id_pc, 32'h0);
        chk("lit_cap0_instr", o_id_instr, 32'h1000_0000);
        chk("lit_cap0_valid", {31'h0, o_id_valid}, 32'h1);
        tick();
        chk("lit_cap1_pc",    o_id_pc, 32'h4);
        chk("lit_cap1_instr", o_id_instr, 32'h1000_0001);

        // Stall three edges with PC=8
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("lit_stall_pc",    o_imem_pc, 32'h8);
        chk("lit_stall_id_pc", o_id_pc, 32'h4);
        chk("lit_stall_cnt",   o_fetch_cnt, 32'd2);
        i_stall = 1'b0; tick();
        chk("lit_cap2_pc",    o_id_pc, 32'h8);
        chk("lit_cap2_instr", o_id_instr, 32'h1000_0002);
        chk("lit_cap2_cnt",   o_fetch_cnt, 32'd3);

        // Redirect to 0x40 while PC=0xC
        chk("lit_pre_redir_pc", o_imem_pc, 32'hC);
        i_redirect = 1'b1; i_redirect_target = 32'h40; tick();
        chk("lit_redir_pc",     o_imem_pc, 32'h40);
        chk("lit_redir_valid",  {31'h0, o_id_valid}, 32'h0);
        chk("lit_redir_instr",  o_id_instr, 32'h0000_0013);
        chk("lit_redir_bubble", o_bubble_cnt, 32'd1);
        i_redirect = 1'b0; tick();
        chk("lit_tgt_pc",    o_id_pc, 32'h40);
        chk("lit_tgt_valid", {31'h0, o_id_valid}, 32'h1);

        // Redirect wins over stall
        i_redirect = 1'b1; i_stall = 1'b1; i_redirect_target = 32'h80; tick();
        chk("lit_rs_pc",     o_imem_pc, 32'h80);
        chk("lit_rs_valid",  {31'h0, o_id_valid}, 32'h0);
        chk("lit_rs_bubble", o_bubble_cnt, 32'd2);
        i_stall = 1'b0;

        // Misaligned target
        i_redirect_target = 32'h46; tick();
        chk("lit_mis_pc",  o_imem_pc, 32'h44);
        chk("lit_mis_flag", {31'h0, o_misalign}, 32'h1);
        i_redirect = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("lit_mis_sticky", {31'h0, o_misalign}, 32'h1);

        // PC wrap at top of address space
        i_redirect = 1'b1; i_redirect_target = 32'hFFFF_FFFC; tick();
        i_redirect = 1'b0; tick();
        chk("lit_wrap_pc",    o_imem_pc, 32'h0);
        chk("lit_wrap_id_pc", o_id_pc, 32'hFFFF_FFFC);
        chk("lit_wrap_pc4",   o_id_pc4, 32'h0);
        chk("lit_wrap_instr", o_id_instr, 32'h1000_0FFF);

        // Reset concurrent with redirect and stall
        i_rst = 1'b1; i_redirect = 1'b1; i_stall = 1'b1; i_redirect_target = 32'h102; tick();
        chk("lit_rr_pc",     o_imem_pc, RESET_VEC);
        chk("lit_rr_valid",  {31'h0, o_id_valid}, 32'h0);
        chk("lit_rr_mis",    {31'h0, o_misalign}, 32'h0);
        chk("lit_rr_bubble", o_bubble_cnt, 32'h0);
        chk("lit_rr_fetch",  o_fetch_cnt, 32'h0);
        i_rst = 1'b0; i_redirect = 1'b0; i_stall = 1'b0; tick();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            i_rst      = ($urandom_range(0, 299) == 0);
            i_stall    = ($urandom_range(0, 3) == 0);
            i_redirect = ($urandom_range(0, 7) == 0);
            i_redirect_target = $urandom();
            if ($urandom_range(0, 3) != 0) i_redirect_target[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) i_redirect_target = 32'hFFFF_FFF0 | (i_redirect_target & 32'hC);
            tick();
        end
        i_rst = 1'b0; i_stall = 1'b0; i_redirect = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
